// File: rtl/ram_sdp_be.sv
// Simple-dual-port RAM with byte enables, selectable read-during-write and an optional output register.
// A clear engine zeroes the whole array after reset or on request, one word per cycle.
module ram_sdp_be #(
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 64,
    parameter bit OUT_REG     = 1'b0,
    parameter bit WRITE_FIRST = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    output logic                    busy,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid
);

    localparam int NB = DATA_WIDTH / 8;
    localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef enum logic {CLEAR, READY} state_t;

    state_t                state;
    logic [AW-1:0]         ptr;
    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    logic [AW-1:0]         wr_idx;
    logic [AW-1:0]         rd_idx;
    logic                  wr_in;
    logic                  rd_in;
    logic                  wr_go;
    logic                  rd_go;
    logic [DATA_WIDTH-1:0] wr_merged;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  s_valid;
    logic [DATA_WIDTH-1:0] s_data;

    assign wr_idx = wr_addr[AW-1:0];
    assign rd_idx = rd_addr[AW-1:0];
    assign wr_in  = ({1'b0, wr_addr} < DEPTH_W);
    assign rd_in  = ({1'b0, rd_addr} < DEPTH_W);
    assign wr_go  = (state == READY) && wr_en && wr_in;
    assign rd_go  = (state == READY) && rd_en;
    // busy is the FSM state seen from outside: high exactly while CLEAR owns the array.
    assign busy   = (state == CLEAR);

    always_comb begin
        wr_merged = mem[wr_idx];
        for (int b = 0; b < NB; b++) begin
            if (wr_be[b]) wr_merged[8*b +: 8] = wr_data[8*b +: 8];
        end
    end

    always_comb begin
        rd_word = '0;
        if (rd_in) begin
            if (WRITE_FIRST && wr_go && (wr_idx == rd_idx)) rd_word = wr_merged;
            else                                             rd_word = mem[rd_idx];
        end
    end

    // The array itself has no reset; the clear engine owns it while in CLEAR.
    always_ff @(posedge clk) begin
        if (state == CLEAR) mem[ptr] <= '0;
        else if (wr_go)     mem[wr_idx] <= wr_merged;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLEAR;
            ptr   <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    if (ptr == LAST) begin
                        state <= READY;
                        ptr   <= '0;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                READY: begin
                    if (clear) begin
                        state <= CLEAR;
                        ptr   <= '0;
                    end
                end
                default: begin
                    state <= CLEAR;
                    ptr   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_valid <= 1'b0;
            s_data  <= '0;
        end else begin
            s_valid <= rd_go;
            if (rd_go) s_data <= rd_word;
        end
    end

    generate
        if (OUT_REG) begin : g_out_reg
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_valid <= 1'b0;
                    rd_data  <= '0;
                end else begin
                    rd_valid <= s_valid;
                    if (s_valid) rd_data <= s_data;
                end
            end
        end else begin : g_no_out_reg
            assign rd_valid = s_valid;
            assign rd_data  = s_data;
        end
    endgenerate

endmodule

// File: tb/tb_ram_sdp_be.sv
// Bench for ram_sdp_be: u0 is OUT_REG=0/WRITE_FIRST=0, u1 is OUT_REG=1/WRITE_FIRST=1.
// Both share one stimulus stream; each is checked at its own read latency.
module tb_ram_sdp_be;

    localparam int AW    = 12;
    localparam int DW    = 32;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          clear;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [3:0]    wr_be;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          busy0, busy1;
    logic [DW-1:0] rd_data0, rd_data1;
    logic          rd_valid0, rd_valid1;

    int n_tests = 0;
    int n_fail  = 0;

    ram_sdp_be #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .OUT_REG(1'b0), .WRITE_FIRST(1'b0)) u0 (
        .clk(clk), .rst(rst), .clear(clear), .busy(busy0),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_valid(rd_valid0)
    );

    ram_sdp_be #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .OUT_REG(1'b1), .WRITE_FIRST(1'b1)) u1 (
        .clk(clk), .rst(rst), .clear(clear), .busy(busy1),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1)
    );

    // Clock and reset
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, want finish before 500000ns");
        $fatal(1);
    end

    // Driver tasks: inputs change 1ns after a rising edge; outputs are sampled there too.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        clear = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_data = '0; wr_be = '0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] d0, output logic v0,
                           output logic [DW-1:0] d1, output logic v1);
        rd_en = 1'b1; rd_addr = a;
        tick();
        rd_en = 1'b0; wr_en = 1'b0;
        d0 = rd_data0; v0 = rd_valid0;
        tick();
        d1 = rd_data1; v1 = rd_valid1;
    endtask

    task automatic test_reset;
        int cnt;
        rst = 1'b1;
        idle_inputs();
        repeat (3) tick();
        n_tests++;
        if ({busy0, busy1} !== 2'b11) begin
            n_fail++; $display("FAIL reset_busy: got %b want 11", {busy0, busy1});
        end
        n_tests++;
        if ({rd_valid0, rd_valid1} !== 2'b00) begin
            n_fail++; $display("FAIL reset_valid: got %b want 00", {rd_valid0, rd_valid1});
        end
        n_tests++;
        if (rd_data0 !== '0 || rd_data1 !== '0) begin
            n_fail++; $display("FAIL reset_data: got %h/%h want 0/0", rd_data0, rd_data1);
        end
        rst = 1'b0;
        cnt = 0;
        while (busy0 && cnt < 200) begin
            tick();
            cnt++;
        end
        n_tests++;
        if (cnt !== DEPTH) begin
            n_fail++; $display("FAIL reset_clear_len: got %0d want %0d", cnt, DEPTH);
        end
        n_tests++;
        if (busy1 !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy1_low: got %b want 0", busy1);
        end
    endtask

    task automatic test_read_zero;
        logic e0, e1;
        for (int i = 0; i < DEPTH + 2; i++) begin
            rd_en   = (i < DEPTH);
            rd_addr = AW'(i);
            tick();
            e0 = (i < DEPTH);
            e1 = (i >= 1) && (i <= DEPTH);
            n_tests++;
            if (rd_valid0 !== e0 || (e0 && rd_data0 !== '0) || rd_valid1 !== e1 || (e1 && rd_data1 !== '0)) begin
                n_fail++;
                $display("FAIL read_zero[%0d]: got v0=%b d0=%h v1=%b d1=%h want v0=%b v1=%b d=0",
                         i, rd_valid0, rd_data0, rd_valid1, rd_data1, e0, e1);
            end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_byte_enable;
        logic [AW-1:0] ta [4];
        logic [DW-1:0] te [4];
        logic [DW-1:0] d0, d1;
        logic          v0, v1;
        ta = '{12'd5, 12'd0, 12'd100, 12'd36};
        te = '{32'hDEADBEAA, 32'h0, 32'h0, 32'h36363636};
        do_write(12'd5,  32'hDEADBEEF, 4'b1111);
        do_write(12'd5,  32'h000000AA, 4'b0001);
        do_write(12'd5,  32'h00000000, 4'b0000);
        do_write(12'd64, 32'hFFFFFFFF, 4'b1111);
        do_write(12'd36, 32'h36363636, 4'b1111);
        for (int k = 0; k < 4; k++) begin
            do_read(ta[k], d0, v0, d1, v1);
            n_tests++;
            if (v0 !== 1'b1 || d0 !== te[k] || v1 !== 1'b1 || d1 !== te[k]) begin
                n_fail++;
                $display("FAIL byte_enable addr %0d: got v0=%b d0=%h v1=%b d1=%h want v=1 d=%h",
                         ta[k], v0, d0, v1, d1, te[k]);
            end
        end
    endtask

    task automatic test_collision;
        logic [DW-1:0] d0, d1;
        logic          v0, v1;
        wr_en = 1'b1; wr_addr = 12'd9; wr_data = 32'h12345678; wr_be = 4'b1111;
        do_read(12'd9, d0, v0, d1, v1);
        n_tests++;
        if (v0 !== 1'b1 || d0 !== 32'h0 || v1 !== 1'b1 || d1 !== 32'h12345678) begin
            n_fail++; $display("FAIL collision_full: got d0=%h d1=%h want d0=00000000 d1=12345678", d0, d1);
        end
        wr_en = 1'b1; wr_addr = 12'd10; wr_data = 32'h12345678; wr_be = 4'b0011;
        do_read(12'd10, d0, v0, d1, v1);
        n_tests++;
        if (v0 !== 1'b1 || d0 !== 32'h0 || v1 !== 1'b1 || d1 !== 32'h00005678) begin
            n_fail++; $display("FAIL collision_partial: got d0=%h d1=%h want d0=00000000 d1=00005678", d0, d1);
        end
        do_read(12'd9, d0, v0, d1, v1);
        n_tests++;
        if (d0 !== 32'h12345678 || d1 !== 32'h12345678) begin
            n_fail++; $display("FAIL collision_stored: got d0=%h d1=%h want 12345678", d0, d1);
        end
        do_write(12'd12, 32'hCAFEF00D, 4'b1111);
        do_read(12'd12, d0, v0, d1, v1);
        n_tests++;
        if (v0 !== 1'b1 || d0 !== 32'hCAFEF00D || v1 !== 1'b1 || d1 !== 32'hCAFEF00D) begin
            n_fail++; $display("FAIL write_then_read: got d0=%h d1=%h want cafef00d", d0, d1);
        end
        wr_en = 1'b1; wr_addr = 12'd11; wr_data = 32'hFFFFFFFF; wr_be = 4'b1111;
        do_read(12'd5, d0, v0, d1, v1);
        n_tests++;
        if (d0 !== 32'hDEADBEAA || d1 !== 32'hDEADBEAA) begin
            n_fail++; $display("FAIL diff_addr_read: got d0=%h d1=%h want deadbeaa", d0, d1);
        end
        do_read(12'd11, d0, v0, d1, v1);
        n_tests++;
        if (d0 !== 32'hFFFFFFFF || d1 !== 32'hFFFFFFFF) begin
            n_fail++; $display("FAIL diff_addr_write: got d0=%h d1=%h want ffffffff", d0, d1);
        end
    endtask

    task automatic test_back_to_back;
        logic          e0v, e1v;
        logic [DW-1:0] e0d, e1d;
        do_write(12'd1, 32'h11111111, 4'b1111);
        do_write(12'd2, 32'h22222222, 4'b1111);
        do_write(12'd3, 32'h33333333, 4'b1111);
        for (int k = 0; k < 5; k++) begin
            rd_en   = (k < 3);
            rd_addr = AW'(k + 1);
            tick();
            e0v = (k < 3);
            e0d = 32'h11111111 * DW'(k + 1);
            e1v = (k >= 1) && (k <= 3);
            e1d = 32'h11111111 * DW'(k);
            n_tests++;
            if (rd_valid0 !== e0v || (e0v && rd_data0 !== e0d) || rd_valid1 !== e1v || (e1v && rd_data1 !== e1d)) begin
                n_fail++;
                $display("FAIL back_to_back[+%0d]: got v0=%b d0=%h v1=%b d1=%h want v0=%b d0=%h v1=%b d1=%h",
                         k + 1, rd_valid0, rd_data0, rd_valid1, rd_data1, e0v, e0d, e1v, e1d);
            end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_clear;
        int            cnt;
        int            stray;
        logic [AW-1:0] ta [5];
        logic [DW-1:0] d0, d1;
        logic          v0, v1;
        ta = '{12'd1, 12'd2, 12'd3, 12'd5, 12'd36};
        cnt = 0;
        clear = 1'b1; rd_en = 1'b1; rd_addr = 12'd5;
        tick();
        clear = 1'b0; rd_en = 1'b0;
        if (busy0) cnt++;
        n_tests++;
        if (busy0 !== 1'b1 || busy1 !== 1'b1) begin
            n_fail++; $display("FAIL clear_busy_rise: got %b%b want 11", busy0, busy1);
        end
        n_tests++;
        if (rd_valid0 !== 1'b1 || rd_data0 !== 32'hDEADBEAA) begin
            n_fail++; $display("FAIL clear_inflight_u0: got v=%b d=%h want v=1 d=deadbeaa", rd_valid0, rd_data0);
        end
        tick();
        if (busy0) cnt++;
        n_tests++;
        if (rd_valid1 !== 1'b1 || rd_data1 !== 32'hDEADBEAA) begin
            n_fail++; $display("FAIL clear_inflight_u1: got v=%b d=%h want v=1 d=deadbeaa", rd_valid1, rd_data1);
        end
        stray = 0;
        wr_en = 1'b1; wr_addr = 12'd2; wr_data = 32'hFFFFFFFF; wr_be = 4'b1111;
        rd_en = 1'b1; rd_addr = 12'd2;
        while (busy0 && cnt < 200) begin
            tick();
            if (busy0) cnt++;
            if (rd_valid0 || rd_valid1) stray++;
        end
        idle_inputs();
        n_tests++;
        if (cnt !== DEPTH) begin
            n_fail++; $display("FAIL clear_len: got %0d want %0d", cnt, DEPTH);
        end
        n_tests++;
        if (stray !== 0) begin
            n_fail++; $display("FAIL clear_blocked_reads: got %0d valid pulses want 0", stray);
        end
        for (int k = 0; k < 5; k++) begin
            do_read(ta[k], d0, v0, d1, v1);
            n_tests++;
            if (v0 !== 1'b1 || d0 !== '0 || v1 !== 1'b1 || d1 !== '0) begin
                n_fail++;
                $display("FAIL after_clear addr %0d: got v0=%b d0=%h v1=%b d1=%h want v=1 d=0",
                         ta[k], v0, d0, v1, d1);
            end
        end
    endtask

    task automatic test_rst_mid;
        int            cnt;
        logic [DW-1:0] d0, d1;
        logic          v0, v1;
        do_write(12'd7, 32'hA5A5A5A5, 4'b1111);
        do_read(12'd7, d0, v0, d1, v1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        repeat (30) tick();
        n_tests++;
        if (busy0 !== 1'b1 || rd_data0 !== 32'hA5A5A5A5 || rd_data1 !== 32'hA5A5A5A5) begin
            n_fail++;
            $display("FAIL clear_holds_rd_data: got busy=%b d0=%h d1=%h want busy=1 d=a5a5a5a5",
                     busy0, rd_data0, rd_data1);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if ({busy0, busy1} !== 2'b11 || {rd_valid0, rd_valid1} !== 2'b00 || rd_data0 !== '0 || rd_data1 !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: got busy=%b%b v=%b%b d0=%h d1=%h want busy=11 v=00 d=0",
                     busy0, busy1, rd_valid0, rd_valid1, rd_data0, rd_data1);
        end
        tick();
        tick();
        rst = 1'b0;
        cnt = 0;
        while (busy0 && cnt < 200) begin
            tick();
            cnt++;
        end
        n_tests++;
        if (cnt !== DEPTH) begin
            n_fail++; $display("FAIL mid_reset_clear_len: got %0d want %0d", cnt, DEPTH);
        end
        do_read(12'd7, d0, v0, d1, v1);
        n_tests++;
        if (v0 !== 1'b1 || d0 !== '0 || v1 !== 1'b1 || d1 !== '0) begin
            n_fail++; $display("FAIL mid_reset_cleared: got v0=%b d0=%h v1=%b d1=%h want v=1 d=0", v0, d0, v1, d1);
        end
    endtask

    initial begin
        test_reset();
        test_read_zero();
        test_byte_enable();
        test_collision();
        test_back_to_back();
        test_clear();
        test_rst_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_sdp_be.md
# ram_sdp_be

Parametrised simple-dual-port RAM with one write port and one read port, per-byte write enables, selectable read-during-write behaviour and an optional output register. A built-in clear engine zeroes the whole array after reset or on request. It is the next-generation storage block for datapaths that need concurrent read and write, partial-word updates and a known initial memory state.

## Interface
- ADDR_WIDTH, 12, address width of both ports.
- DATA_WIDTH, 32, word width; must be a multiple of 8.
- DEPTH, 64, number of words; 2 ≤ DEPTH ≤ 2^ADDR_WIDTH.
- OUT_REG, 0, 1 adds a pipeline register after the array read.
- WRITE_FIRST, 0, 1 makes same-address reads return the newly written data.

- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- clear  in  1  one-cycle request to zero the whole array.
- busy  out  1  high while the clear engine runs; ports are blocked.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.
- wr_be  in  DATA_WIDTH/8  byte enables; bit i covers wr_data[8i+7:8i].
- rd_en  in  1  read request.
- rd_addr  in  ADDR_WIDTH  read address.
- rd_data  out  DATA_WIDTH  read data.
- rd_valid  out  1  rd_data holds the result of an accepted read.

## Operation
- FSM states: CLEAR, READY.
- Reset (async assert): state=CLEAR, clear pointer=0, busy=1, rd_data=0, rd_valid=0, and the internal pipeline stage is zeroed. The array is not reset directly; the clear engine zeroes it.
- CLEAR: each cycle, write 0 to mem[ptr] and increment ptr. When ptr==DEPTH-1 is written, go to READY.
- CLEAR: clear input is ignored. wr_en is dropped. rd_en is not accepted, so it yields no rd_valid.
- READY: clear=1 moves to CLEAR with ptr=0 on the next edge. Any wr_en or rd_en in that same cycle is still serviced.
- Write: wr_en with wr_addr<DEPTH updates only the bytes whose wr_be bit is set. wr_be=0 is a no-op. wr_addr≥DEPTH is ignored.
- Read: rd_en is accepted in READY. If rd_addr≥DEPTH, the returned data is 0.
- Same-address collision (wr_en & rd_en & wr_addr==rd_addr, both valid):
  - WRITE_FIRST=0: return the old word.
  - WRITE_FIRST=1: return the merged word (enabled bytes new, others old).
- Different-address concurrent write and read never interact.
- rd_data holds its last value when no read completes. It is not cleared by the clear engine.

## Timing
- Read latency L = 1 + OUT_REG cycles from the rd_en edge to rd_data/rd_valid.
- rd_valid is high for exactly one cycle per accepted read. Back-to-back reads give back-to-back valid at full throughput.
- A write is visible to a read issued on the following cycle, in both modes.
- Clear duration: after rst deasserts, busy is high for exactly DEPTH rising edges. The first cycle with busy=0 accepts traffic.
- clear request in READY: busy rises on the next edge and stays high for DEPTH edges.
- Reads in flight when CLEAR starts still complete with the pre-clear data and rd_valid.
- rst asserted mid-clear or mid-read: everything returns to the reset values immediately, and the clear restarts from address 0 after release. In-flight reads are lost.

## Test plan
- Reset release, DEPTH=64: busy stays 1 for 64 cycles, then 0. Reading addresses 0..63 afterwards returns 0 with rd_valid after L cycles.
- Write 0xDEADBEEF to addr 5 with wr_be=4'b1111, then 0x000000AA with wr_be=4'b0001 -> a read of addr 5 returns 0xDEADBEAA.
- Same-cycle write of 0x12345678 and read of addr 9 (old value 0x0):
  - WRITE_FIRST=0 -> 0x00000000.
  - WRITE_FIRST=1 -> 0x12345678.
  - Repeat with wr_be=4'b0011 and WRITE_FIRST=1 -> 0x00005678.
- OUT_REG=1, reads of addrs 1,2,3 on consecutive cycles -> rd_valid high on cycles +2,+3,+4 with the matching data. With OUT_REG=0, valid appears on cycles +1..+3.
- clear pulse in READY after filling memory -> busy high for 64 cycles. Writes and reads during that window are dropped with no rd_valid. All reads afterwards return 0.
- rst asserted at clear ptr=30 -> busy stays 1, rd_valid=0 and rd_data=0 immediately. After release, busy lasts a full 64 cycles.
